// File: rtl/snake_pkg.sv
// Shared constants for the snake movement controller:
// direction codes, FSM state encoding and position packing.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_CALC = 3'd3;
    localparam logic [2:0] ST_PUSH = 3'd4;
    localparam logic [2:0] ST_POP  = 3'd5;
    localparam logic [2:0] ST_DEAD = 3'd6;

    // Caller truncates the result to 2*w bits.
    function automatic logic [31:0] pack_pos(
        input logic [15:0] y,
        input logic [15:0] x,
        input int          w
    );
        return ({16'd0, y} << w) | {16'd0, x};
    endfunction

    // Opposite directions differ only in the upper bit.
    function automatic logic is_reverse(
        input logic [1:0] req,
        input logic [1:0] cur
    );
        return req == (cur ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational one-step head move with wall detection;
// shared with the food/collision checker.
module snake_next_pos
    import snake_pkg::*;
#(
    parameter int COORD_W = 3
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               wall
);

    always_comb begin
        next_x = x;
        next_y = y;
        wall   = 1'b0;
        case (dir)
            DIR_UP: begin
                wall   = (y == '0);
                next_y = y - COORD_W'(1);
            end
            DIR_RIGHT: begin
                wall   = (&x);
                next_x = x + COORD_W'(1);
            end
            DIR_DOWN: begin
                wall   = (&y);
                next_y = y + COORD_W'(1);
            end
            default: begin
                wall   = (x == '0);
                next_x = x - COORD_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Tick-driven movement controller feeding push/pop/position
// to body_stack; tracks head, length and wall death.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int MAX_LEN = 8,
    parameter int INIT_X  = 1,
    parameter int INIT_Y  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         tick,
    input  logic [1:0]                   dir_in,
    input  logic                         grow,
    output logic                         push,
    output logic                         pop,
    output logic [2*COORD_W-1:0]         pos_out,
    output logic [COORD_W-1:0]           head_x,
    output logic [COORD_W-1:0]           head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [1:0]                   dir_cur,
    output logic                         busy,
    output logic                         dead
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int POS_W = 2 * COORD_W;

    logic [2:0]         state;
    logic               grow_q;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic               wall;

    snake_next_pos #(
        .COORD_W (COORD_W)
    ) u_next (
        .x      (head_x),
        .y      (head_y),
        .dir    (dir_cur),
        .next_x (nx),
        .next_y (ny),
        .wall   (wall)
    );

    // Outputs are registered alongside the state they belong to,
    // so push/pop/busy/dead change on the edge that enters a state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            push    <= 1'b0;
            pop     <= 1'b0;
            pos_out <= '0;
            head_x  <= COORD_W'(INIT_X);
            head_y  <= COORD_W'(INIT_Y);
            length  <= '0;
            dir_cur <= DIR_RIGHT;
            busy    <= 1'b0;
            dead    <= 1'b0;
            grow_q  <= 1'b0;
        end else begin
            push <= 1'b0;
            pop  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_INIT;
                        push    <= 1'b1;
                        pos_out <= POS_W'(pack_pos(16'(INIT_Y), 16'(INIT_X), COORD_W));
                        head_x  <= COORD_W'(INIT_X);
                        head_y  <= COORD_W'(INIT_Y);
                        busy    <= 1'b1;
                    end
                end
                ST_INIT: begin
                    length <= LEN_W'(1);
                    state  <= ST_RUN;
                    busy   <= 1'b0;
                end
                ST_RUN: begin
                    if (tick) begin
                        grow_q <= grow;
                        if (!is_reverse(dir_in, dir_cur)) begin
                            dir_cur <= dir_in;
                        end
                        state <= ST_CALC;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (wall) begin
                        state <= ST_DEAD;
                        dead  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_PUSH;
                        push    <= 1'b1;
                        pos_out <= POS_W'(pack_pos(16'(ny), 16'(nx), COORD_W));
                    end
                end
                ST_PUSH: begin
                    head_x <= nx;
                    head_y <= ny;
                    if (grow_q && (length < LEN_W'(MAX_LEN))) begin
                        length <= length + LEN_W'(1);
                        state  <= ST_RUN;
                        busy   <= 1'b0;
                    end else begin
                        state <= ST_POP;
                        pop   <= 1'b1;
                    end
                end
                ST_POP: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
                ST_DEAD: begin
                    state <= ST_DEAD;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: expected push/pop events
// are queued by the stimulus and consumed by a negedge monitor.
module tb_snake_body_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_in = 2'b01;
    logic       grow = 1'b0;
    logic       push;
    logic       pop;
    logic [5:0] pos_out;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [3:0] length;
    logic [1:0] dir_cur;
    logic       busy;
    logic       dead;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit       is_push;
        bit [5:0] pos;
        int       cyc;
    } ev_t;

    ev_t q[$];

    snake_body_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tick    (tick),
        .dir_in  (dir_in),
        .grow    (grow),
        .push    (push),
        .pop     (pop),
        .pos_out (pos_out),
        .head_x  (head_x),
        .head_y  (head_y),
        .length  (length),
        .dir_cur (dir_cur),
        .busy    (busy),
        .dead    (dead)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (push && pop) begin
            checks++;
            errors++;
            $display("FAIL push_pop_overlap at cyc %0d", cyc);
        end else if (push || pop) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event push=%0b pop=%0b pos=%0h cyc=%0d required none",
                         push, pop, pos_out, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (push !== e.is_push || cyc != e.cyc ||
                    (e.is_push && pos_out !== e.pos)) begin
                    errors++;
                    $display("FAIL event actual push=%0b pos=%0h cyc=%0d required push=%0b pos=%0h cyc=%0d",
                             push, pos_out, cyc, e.is_push, e.pos, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        int e;
        start = 1'b1;
        step();
        start = 1'b0;
        e = cyc;
        q.push_back('{is_push: 1'b1, pos: 6'b001001, cyc: e});
        step();
        step();
    endtask

    task automatic do_tick(input logic [1:0] d, input logic g,
                           input int ex, input int ey, input bit exp_pop);
        int t;
        dir_in = d;
        grow = g;
        tick = 1'b1;
        step();
        tick = 1'b0;
        grow = 1'b0;
        t = cyc;
        q.push_back('{is_push: 1'b1, pos: {3'(ey), 3'(ex)}, cyc: t + 1});
        if (exp_pop) q.push_back('{is_push: 1'b0, pos: 6'd0, cyc: t + 2});
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_push", 32'(push), 0);
        chk("rst_pop", 32'(pop), 0);
        chk("rst_pos", 32'(pos_out), 0);
        chk("rst_head_x", 32'(head_x), 1);
        chk("rst_head_y", 32'(head_y), 1);
        chk("rst_length", 32'(length), 0);
        chk("rst_dir", 32'(dir_cur), 1);
        chk("rst_busy_dead", 32'({busy, dead}), 0);

        // Tick in IDLE is ignored.
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();

        do_start();
        chk("start_length", 32'(length), 1);
        chk("start_busy", 32'(busy), 0);

        do_tick(2'b01, 1'b0, 2, 1, 1'b1);
        chk("move_head_x", 32'(head_x), 2);
        chk("move_length", 32'(length), 1);

        do_tick(2'b01, 1'b1, 3, 1, 1'b0);
        do_tick(2'b01, 1'b1, 4, 1, 1'b0);
        do_tick(2'b01, 1'b1, 5, 1, 1'b0);
        chk("grow3_length", 32'(length), 4);

        do_tick(2'b10, 1'b1, 5, 2, 1'b0);
        do_tick(2'b10, 1'b1, 5, 3, 1'b0);
        do_tick(2'b10, 1'b1, 5, 4, 1'b0);
        do_tick(2'b10, 1'b1, 5, 5, 1'b0);
        chk("full_length", 32'(length), 8);
        do_tick(2'b10, 1'b1, 5, 6, 1'b1);
        chk("max_grow_length", 32'(length), 8);
        chk("down_dir", 32'(dir_cur), 2);

        do_tick(2'b01, 1'b0, 6, 6, 1'b1);
        do_tick(2'b11, 1'b0, 7, 6, 1'b1);
        chk("reverse_dir", 32'(dir_cur), 1);
        chk("reverse_head_x", 32'(head_x), 7);

        // Wall hit at x=7 moving right.
        dir_in = 2'b01;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("calc_not_dead", 32'(dead), 0);
        step();
        chk("dead_t2", 32'(dead), 1);
        chk("dead_busy", 32'(busy), 0);
        tick = 1'b1;
        start = 1'b1;
        step();
        tick = 1'b0;
        start = 1'b0;
        repeat (4) step();
        chk("dead_sticky", 32'(dead), 1);
        chk("dead_head", 32'({head_y, head_x}), 32'({3'd6, 3'd7}));
        chk("dead_length", 32'(length), 8);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_dead", 32'(dead), 0);
        chk("reset_length", 32'(length), 0);
        chk("reset_head", 32'({head_y, head_x}), 32'({3'd1, 3'd1}));

        // Second tick lands during CALC and must be dropped.
        do_start();
        dir_in = 2'b01;
        tick = 1'b1;
        step();
        t = cyc;
        q.push_back('{is_push: 1'b1, pos: {3'd1, 3'd2}, cyc: t + 1});
        q.push_back('{is_push: 1'b0, pos: 6'd0, cyc: t + 2});
        dir_in = 2'b10;
        step();
        tick = 1'b0;
        repeat (4) step();
        chk("drop_head", 32'({head_y, head_x}), 32'({3'd1, 3'd2}));
        chk("drop_dir", 32'(dir_cur), 1);

        // Reset while push is high.
        dir_in = 2'b01;
        tick = 1'b1;
        step();
        tick = 1'b0;
        t = cyc;
        q.push_back('{is_push: 1'b1, pos: {3'd1, 3'd3}, cyc: t + 1});
        step();
        chk("pre_reset_push", 32'(push), 1);
        reset = 1'b1;
        step();
        chk("mid_reset_push_pop", 32'({push, pop}), 0);
        chk("mid_reset_idle", 32'({busy, length}), 0);
        chk("mid_reset_head", 32'({head_y, head_x}), 32'({3'd1, 3'd1}));
        reset = 1'b0;
        repeat (3) step();

        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_ctrl.md
# snake_body_ctrl

Movement controller that drives the push/pop side of `body_stack`. On every game tick it computes the next head position from the player direction, pushes it into the body stack and, unless the snake grows on that tick, pops one segment. It also tracks head coordinates, length and wall collision. It sits between the direction/tick logic and `body_stack`, and its `push`, `pop` and `pos_out` outputs connect directly to the stack's `push`, `pop` and `posEnt`.

## Interface
Parameters:
- `COORD_W`, default 3: bits per coordinate. The grid is 2^COORD_W × 2^COORD_W.
- `MAX_LEN`, default 8: maximum body length, equal to the stack depth.
- `INIT_X`, default 1: start head x.
- `INIT_Y`, default 1: start head y.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse that starts a game from IDLE.
- `tick`  in  1: one-cycle game-step pulse.
- `dir_in`  in  2: requested direction. 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1).
- `grow`  in  1: food eaten. Sampled with `tick`.
- `push`  out  1: stack push strobe.
- `pop`  out  1: stack pop strobe.
- `pos_out`  out  2*COORD_W: position to push, packed as {y, x}.
- `head_x`, `head_y`  out  COORD_W each: current head position.
- `length`  out  $clog2(MAX_LEN+1): current segment count.
- `dir_cur`  out  2: direction currently applied.
- `busy`  out  1: high in INIT, CALC, PUSH and POP.
- `dead`  out  1: wall collision occurred. Sticky.

## Operation
- States: IDLE, INIT, RUN, CALC, PUSH, POP, DEAD.
- IDLE: on `start`, go to INIT. `tick` is ignored.
- INIT: `push`=1 for one cycle with `pos_out`={INIT_Y, INIT_X}. Set `length`=1, then go to RUN.
- RUN: on `tick`, latch `dir_in` and `grow`, then go to CALC.
  - A requested direction that reverses `dir_cur` (up/down, left/right) is rejected and `dir_cur` is kept.
  - Otherwise `dir_cur` takes the requested direction.
- CALC: compute `next_head` from the head and `dir_cur`.
  - A wall crossing is x=0 moving left, x=max moving right, y=0 moving up, or y=max moving down.
  - On a wall crossing, go to DEAD. The head is unchanged and nothing is pushed.
  - Otherwise go to PUSH.
- PUSH: `push`=1 and `pos_out`=`next_head`. The head registers update at the end of this cycle.
  - If the latched `grow` is set and `length`<MAX_LEN: `length`+1, then go to RUN.
  - Otherwise go to POP.
- POP: `pop`=1 for one cycle. `length` is unchanged. Go to RUN.
- Growth requested at `length`=MAX_LEN is treated as no growth: push followed by pop.
- DEAD: `dead`=1. `push` and `pop` stay low. `start` and `tick` are ignored. Only `reset` exits this state.
- A `tick` arriving in any state other than RUN is dropped, not queued.
- `push` and `pop` are never asserted in the same cycle.
- `pos_out` holds its last value while `push`=0.
- Coordinate arithmetic is unsigned COORD_W-bit. Wrap-around is never used because a wall crossing is detected first.

## Timing
- Reset values:
  - State IDLE.
  - `push`=0, `pop`=0, `pos_out`=0.
  - `head_x`=INIT_X, `head_y`=INIT_Y.
  - `length`=0, `dir_cur`=01, `busy`=0, `dead`=0.
- Reset asserted in any state, including mid-PUSH or mid-POP, returns all of the above on the next edge. It overrides every other input.
- All outputs are registered.
- `start` sampled at edge E: `push` is high during cycle E+1. RUN is entered at E+2.
- `tick` sampled at edge T in RUN:
  - CALC during T+1.
  - `push` high during T+2.
  - `pop` high during T+3, unless growing.
  - Back in RUN from T+3 when growing, or from T+4 otherwise.
- Minimum tick spacing for no drop: 4 cycles.
- `dead` rises at T+2.
- `length` and the head registers update at T+3.

## Structure
- Package `snake_pkg`:
  - Direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11.
  - FSM state encoding.
  - Function that packs {y, x} into a position word.
- Sub-module `snake_next_pos`: combinational. Takes head x/y and direction and returns the next x/y plus a wall flag. It is reused by the food/collision checker.

## Test plan
- Reset, then `start`, with defaults: `push` pulse in one cycle with `pos_out`=6'b001001, then `length`=1 and `busy`=0.
- `tick` with `dir_in`=01 and `grow`=0 from head (1,1): `push` at T+2 with `pos_out`={1,2}, `pop` at T+3, `head_x`=2, `length`=1.
- `tick` with `grow`=1 three times: three pushes and no pops, `length`=4. At `length`=8, `tick` with `grow`=1 gives push then pop and `length` stays 8.
- `dir_cur`=01 and `tick` with `dir_in`=11: the reversal is rejected, `dir_cur` stays 01 and the head moves right.
- Head at x=7 moving right, then `tick`: `dead`=1 at T+2, no push or pop, and later ticks are ignored. Reset clears `dead`.
- `tick` asserted during CALC is dropped. Reset asserted during PUSH gives `push`=0 next cycle and state IDLE.
